// File: rtl/softex_tcdm_arbiter.sv
// Multi-channel TCDM arbiter: funnels NB_CH initiator ports onto a single target
// port (round-robin or fixed priority) and routes in-order read responses back
// to the requesting channel through a small read-ID FIFO.
module softex_tcdm_arbiter #(
    parameter int unsigned NB_CH           = 4,
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  prio_mode_i,
    input  logic [NB_CH-1:0]      in_req_i,
    output logic [NB_CH-1:0]      in_gnt_o,
    input  logic [NB_CH*AW-1:0]   in_add_i,
    input  logic [NB_CH-1:0]      in_wen_i,
    input  logic [NB_CH*DW/8-1:0] in_be_i,
    input  logic [NB_CH*DW-1:0]   in_data_i,
    output logic [NB_CH-1:0]      in_r_valid_o,
    output logic [NB_CH*DW-1:0]   in_r_data_o,
    output logic                  out_req_o,
    input  logic                  out_gnt_i,
    output logic [AW-1:0]         out_add_o,
    output logic                  out_wen_o,
    output logic [DW/8-1:0]       out_be_o,
    output logic [DW-1:0]         out_data_o,
    input  logic                  out_r_valid_i,
    input  logic [DW-1:0]         out_r_data_i,
    output logic                  busy_o
);

    localparam int unsigned IDX_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BW    = DW / 8;

    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] held_idx_q, held_idx_d;
    logic             held_q, held_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] id_fifo_q [MAX_OUTSTANDING];

    logic             fifo_full, fifo_empty;
    logic [NB_CH-1:0] eligible;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic             req_int, push, pop;

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign busy_o     = !fifo_empty;

    // A read may only be granted when its ID has a FIFO slot, or one frees up this cycle.
    always_comb begin
        for (int c = 0; c < NB_CH; c++) begin
            eligible[c] = in_req_i[c] & (~in_wen_i[c] | ~fifo_full | out_r_valid_i);
        end
    end

    // Winner selection: a stalled winner is held, else fixed priority or round-robin.
    always_comb begin
        logic             hi_valid, lo_valid;
        logic [IDX_W-1:0] hi_idx, lo_idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        win_valid = 1'b0;
        win_idx   = '0;
        hi_valid  = 1'b0;
        lo_valid  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        // Descending scan leaves the lowest eligible index (overall and above last_q).
        for (int c = NB_CH - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                lo_valid = 1'b1;
                lo_idx   = IDX_W'(c);
                if (c > int'(last_q)) begin
                    hi_valid = 1'b1;
                    hi_idx   = IDX_W'(c);
                end
            end
        end
        if (held_q && eligible[held_idx_q]) begin
            win_valid = 1'b1;
            win_idx   = held_idx_q;
        end else if (prio_mode_i || !hi_valid) begin
            win_valid = lo_valid;
            win_idx   = lo_idx;
        end else begin
            win_valid = 1'b1;
            win_idx   = hi_idx;
        end
    end

    // Target-side request mux and grant/response fan-out.
    always_comb begin
        req_int      = win_valid & enable_i & ~clear_i & rst_ni;
        out_req_o    = req_int;
        in_gnt_o     = '0;
        out_add_o    = '0;
        out_wen_o    = 1'b0;
        out_be_o     = '0;
        out_data_o   = '0;
        if (req_int) begin
            in_gnt_o[win_idx] = out_gnt_i;
            out_add_o  = in_add_i[int'(win_idx)*AW +: AW];
            out_wen_o  = in_wen_i[win_idx];
            out_be_o   = in_be_i[int'(win_idx)*BW +: BW];
            out_data_o = in_data_i[int'(win_idx)*DW +: DW];
        end
        pop          = out_r_valid_i & ~fifo_empty & ~clear_i;
        in_r_valid_o = '0;
        if (pop) begin
            in_r_valid_o[id_fifo_q[rd_ptr_q]] = 1'b1;
        end
        in_r_data_o  = {NB_CH{out_r_data_i}};
    end

    // Next-state for FIFO bookkeeping, round-robin pointer and stall hold.
    always_comb begin
        push       = req_int & out_gnt_i & out_wen_o;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        last_d     = (req_int && out_gnt_i) ? win_idx : last_q;
        held_d     = req_int & ~out_gnt_i;
        held_idx_d = win_idx;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            last_d   = IDX_W'(NB_CH - 1);
            held_d   = 1'b0;
        end
    end

    // Control state register; last_q resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= IDX_W'(NB_CH - 1);
            held_q     <= 1'b0;
            held_idx_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            held_q     <= held_d;
            held_idx_q <= held_idx_d;
        end
    end

    // Read-ID storage, written at the tail on each read handshake.
    // NOTE: entries are not reset; cnt_q alone decides which ones are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_fifo_q[wr_ptr_q] <= win_idx;
        end
    end

endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// Directed bench for softex_tcdm_arbiter: a vector table for the steady-state
// arbitration behaviour plus hand-written multi-cycle sequences.
module tb_softex_tcdm_arbiter;

    localparam int NB_CH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  clear_i;
    logic                  enable_i;
    logic                  prio_mode_i;
    logic [NB_CH-1:0]      in_req_i;
    logic [NB_CH-1:0]      in_gnt_o;
    logic [NB_CH*AW-1:0]   in_add_i;
    logic [NB_CH-1:0]      in_wen_i;
    logic [NB_CH*DW/8-1:0] in_be_i;
    logic [NB_CH*DW-1:0]   in_data_i;
    logic [NB_CH-1:0]      in_r_valid_o;
    logic [NB_CH*DW-1:0]   in_r_data_o;
    logic                  out_req_o;
    logic                  out_gnt_i;
    logic [AW-1:0]         out_add_o;
    logic                  out_wen_o;
    logic [DW/8-1:0]       out_be_o;
    logic [DW-1:0]         out_data_o;
    logic                  out_r_valid_i;
    logic [DW-1:0]         out_r_data_i;
    logic                  busy_o;

    int total = 0;
    int bad   = 0;

    softex_tcdm_arbiter #(
        .NB_CH(NB_CH), .DW(DW), .AW(AW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .prio_mode_i(prio_mode_i), .in_req_i(in_req_i), .in_gnt_o(in_gnt_o),
        .in_add_i(in_add_i), .in_wen_i(in_wen_i), .in_be_i(in_be_i),
        .in_data_i(in_data_i), .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
        .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
        .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       en;
        logic       prio;
        logic [3:0] req;
        logic [3:0] wen;
        logic       ogt;
        logic       rv;
        logic       e_req;
        int         e_win;
        logic [3:0] e_gnt;
        logic [3:0] e_rv;
        logic       e_busy;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] addr_of(int c);
        return 32'hA000_0000 + 32'(c * 16);
    endfunction

    function automatic logic [31:0] data_of(int c);
        return 32'hD000_0000 + 32'(c);
    endfunction

    function automatic logic [3:0] be_of(int c);
        return 4'b0001 << c;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and check outputs before the rising edge.
    task automatic step(input string name, input logic clr, input logic en, input logic prio,
                        input logic [3:0] req, input logic [3:0] wen, input logic ogt,
                        input logic rv, input logic e_req, input int e_win,
                        input logic [3:0] e_gnt, input logic [3:0] e_rv, input logic e_busy);
        logic [31:0] rdata;
        @(negedge clk_i);
        rdata         = $urandom;
        clear_i       = clr;
        enable_i      = en;
        prio_mode_i   = prio;
        in_req_i      = req;
        in_wen_i      = wen;
        out_gnt_i     = ogt;
        out_r_valid_i = rv;
        out_r_data_i  = rdata;
        #1;
        check({name, ".req"},   out_req_o,    e_req);
        check({name, ".gnt"},   in_gnt_o,     e_gnt);
        check({name, ".rv"},    in_r_valid_o, e_rv);
        check({name, ".busy"},  busy_o,       e_busy);
        check({name, ".rdata"}, in_r_data_o,  {NB_CH{rdata}});
        if (e_req) begin
            check({name, ".add"},  out_add_o,  addr_of(e_win));
            check({name, ".wen"},  out_wen_o,  wen[e_win]);
            check({name, ".be"},   out_be_o,   be_of(e_win));
            check({name, ".data"}, out_data_o, data_of(e_win));
        end
    endtask

    initial begin
        // Round-robin order with responses trailing one cycle, then an orphan response.
        vecs[0]  = '{1, 0, 4'hF, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 0};
        vecs[1]  = '{1, 0, 4'hF, 4'hF, 1, 1, 1, 1, 4'h2, 4'h1, 1};
        vecs[2]  = '{1, 0, 4'hF, 4'hF, 1, 1, 1, 2, 4'h4, 4'h2, 1};
        vecs[3]  = '{1, 0, 4'hF, 4'hF, 1, 1, 1, 3, 4'h8, 4'h4, 1};
        vecs[4]  = '{1, 0, 4'hF, 4'hF, 1, 1, 1, 0, 4'h1, 4'h8, 1};
        vecs[5]  = '{1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h1, 1};
        vecs[6]  = '{1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h0, 0};
        // Fixed priority: channel 1 beats channel 3 every cycle.
        vecs[7]  = '{1, 1, 4'hA, 4'h0, 1, 0, 1, 1, 4'h2, 4'h0, 0};
        vecs[8]  = '{1, 1, 4'hA, 4'h0, 1, 0, 1, 1, 4'h2, 4'h0, 0};
        vecs[9]  = '{1, 1, 4'hA, 4'h0, 1, 0, 1, 1, 4'h2, 4'h0, 0};
        // Back to round-robin from last=1: 3 then 1.
        vecs[10] = '{1, 0, 4'hA, 4'h0, 1, 0, 1, 3, 4'h8, 4'h0, 0};
        vecs[11] = '{1, 0, 4'hA, 4'h0, 1, 0, 1, 1, 4'h2, 4'h0, 0};
        // Disabled, then grant follows out_gnt_i.
        vecs[12] = '{0, 0, 4'hF, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 0};
        vecs[13] = '{1, 0, 4'h4, 4'h0, 0, 0, 1, 2, 4'h0, 4'h0, 0};
        vecs[14] = '{1, 0, 4'h4, 4'h0, 1, 0, 1, 2, 4'h4, 4'h0, 0};

        for (int c = 0; c < NB_CH; c++) begin
            in_add_i[c*AW +: AW]     = addr_of(c);
            in_data_i[c*DW +: DW]    = data_of(c);
            in_be_i[c*DW/8 +: DW/8]  = be_of(c);
        end

        // Reset with busy-looking inputs: everything must stay quiet.
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        enable_i      = 1'b1;
        prio_mode_i   = 1'b0;
        in_req_i      = 4'hF;
        in_wen_i      = 4'hF;
        out_gnt_i     = 1'b1;
        out_r_valid_i = 1'b1;
        out_r_data_i  = '0;
        #12;
        check("reset.req",  out_req_o,    1'b0);
        check("reset.gnt",  in_gnt_o,     4'h0);
        check("reset.rv",   in_r_valid_o, 4'h0);
        check("reset.busy", busy_o,       1'b0);
        @(negedge clk_i);
        in_req_i      = 4'h0;
        out_r_valid_i = 1'b0;
        rst_ni        = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), 1'b0, vecs[i].en, vecs[i].prio, vecs[i].req,
                 vecs[i].wen, vecs[i].ogt, vecs[i].rv, vecs[i].e_req, vecs[i].e_win,
                 vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_busy);
        end

        // FIFO full (last=2): reads go 3,0,1,2, then a 5th read is blocked.
        step("full1", 0, 1, 0, 4'hF, 4'hF, 1, 0, 1, 3, 4'h8, 4'h0, 0);
        step("full2", 0, 1, 0, 4'hF, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 1);
        step("full3", 0, 1, 0, 4'hF, 4'hF, 1, 0, 1, 1, 4'h2, 4'h0, 1);
        step("full4", 0, 1, 0, 4'hF, 4'hF, 1, 0, 1, 2, 4'h4, 4'h0, 1);
        step("full5", 0, 1, 0, 4'h8, 4'h8, 1, 0, 0, 0, 4'h0, 4'h0, 1);
        step("fullw", 0, 1, 0, 4'hA, 4'h8, 1, 0, 1, 1, 4'h2, 4'h0, 1);
        // Push and pop together at full: head 3 returns, occupancy stays 4.
        step("pushpop", 0, 1, 0, 4'h8, 4'h8, 1, 1, 1, 3, 4'h8, 4'h8, 1);
        step("stillfull", 0, 1, 0, 4'h8, 4'h8, 1, 0, 0, 0, 4'h0, 4'h0, 1);
        step("drain0", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h1, 1);
        step("drain1", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h2, 1);
        step("drain2", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h4, 1);
        step("drain3", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h8, 1);
        step("drained", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h0, 0);

        // Stall (last=3): channel 2 held while channel 0 joins, although RR would pick 0.
        step("stall1", 0, 1, 0, 4'h4, 4'h0, 0, 0, 1, 2, 4'h0, 4'h0, 0);
        step("stall2", 0, 1, 0, 4'h5, 4'h0, 0, 0, 1, 2, 4'h0, 4'h0, 0);
        step("stall3", 0, 1, 0, 4'h5, 4'h0, 0, 0, 1, 2, 4'h0, 4'h0, 0);
        step("stallg", 0, 1, 0, 4'h5, 4'h0, 1, 0, 1, 2, 4'h4, 4'h0, 0);
        step("stalln", 0, 1, 0, 4'h5, 4'h0, 1, 0, 1, 0, 4'h1, 4'h0, 0);

        // Mid-operation reset with two reads outstanding (last=0: grants 1 then 0).
        step("rst1", 0, 1, 0, 4'h3, 4'h3, 1, 0, 1, 1, 4'h2, 4'h0, 0);
        step("rst2", 0, 1, 0, 4'h3, 4'h3, 1, 0, 1, 0, 4'h1, 4'h0, 1);
        step("rst3", 0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rstpulse.busy", busy_o,    1'b0);
        check("rstpulse.req",  out_req_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("rstdrop", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h0, 0);
        step("rstfirst", 0, 1, 0, 4'hF, 4'hF, 1, 0, 1, 0, 4'h1, 4'h0, 0);

        // Clear with one read outstanding: request suppressed, ID dropped, RR pointer back to 3.
        step("clr", 1, 1, 0, 4'hF, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 1);
        step("clrdrop", 0, 1, 0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h0, 0);
        step("clrfirst", 0, 1, 0, 4'hF, 4'h0, 1, 0, 1, 0, 4'h1, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
